// File: rtl/uart_pkg.sv
// Shared UART constants: character-length encodings, baud divider limits and
// the default receive-idle timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } cfg_bits_e;

  localparam int BAUD_LIMIT_115200 = 867;
  localparam int BAUD_LIMIT_19200  = 5207;
  localparam int BAUD_LIMIT_9600   = 10415;

  // Four characters of ten bits at 868 clocks per bit.
  localparam int TIMEOUT_CYC_DEF = 34720;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic first-word-fall-through circular FIFO with wrap-bit pointers.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [DATA_WIDTH-1:0]    o_rd_data,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_wr_accept,
  output logic                     o_rd_accept
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_rd_acc = i_rd_en && !w_empty;
  assign w_wr_acc = i_wr_en && (!w_full || w_rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; stale words are hidden while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_rd_valid  = !w_empty;
  assign o_level     = r_wr_ptr - r_rd_ptr;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_wr_accept = w_wr_acc;
  assign o_rd_accept = w_rd_acc;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: masks each received character to the configured length,
// queues it, and reports level, sticky overflow and idle timeout.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  input  logic                     i_wr_en,
  input  logic [1:0]               i_cfg_bits,
  output logic [DATA_WIDTH-1:0]    o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  input  logic                     i_clr_ovf,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic                     o_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

  logic [DATA_WIDTH-1:0] w_masked;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_empty;
  logic                  r_ovf;
  logic [TW-1:0]         r_to_cnt;

  // Clears every bit at or above the character length selected by cfg.
  function automatic logic [DATA_WIDTH-1:0] mask_char(input logic [DATA_WIDTH-1:0] d,
                                                      input cfg_bits_e cfg);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < 5 + int'(cfg)) m[i] = d[i];
    end
    return m;
  endfunction

  assign w_masked = mask_char(i_wr_data, cfg_bits_e'(i_cfg_bits));

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_wr_data   (w_masked),
    .i_wr_en     (i_wr_en),
    .i_rd_en     (i_rd_ready),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_level     (o_level),
    .o_full      (o_full),
    .o_empty     (w_empty),
    .o_wr_accept (w_wr_acc),
    .o_rd_accept (w_rd_acc)
  );

  // A dropped character outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (i_wr_en && !w_wr_acc) begin
      r_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // Dropped writes are not activity, so they leave the idle count running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_wr_acc || w_rd_acc || w_empty) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign o_empty    = w_empty;
  assign o_overflow = r_ovf;
  assign o_timeout  = (r_to_cnt == TO_MAX) && !w_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue of expected characters is filled
// as writes are driven and drained as the DUT presents popped data.
module tb_uart_rx_fifo;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int TO  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_wr_en = 1'b0;
  logic [1:0]    i_cfg_bits = 2'b11;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          i_rd_ready = 1'b0;
  logic          i_clr_ovf = 1'b0;
  logic [4:0]    o_level;
  logic          o_full;
  logic          o_empty;
  logic          o_overflow;
  logic          o_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEP),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wr_data  (i_wr_data),
    .i_wr_en    (i_wr_en),
    .i_cfg_bits (i_cfg_bits),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .i_clr_ovf  (i_clr_ovf),
    .o_level    (o_level),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow),
    .o_timeout  (o_timeout)
  );

  // One clock of stimulus with scoreboard pop/push and status comparison.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic [1:0] cfg,
                      input logic rdy, input logic clr);
    logic          pop;
    logic          acc;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] msk;
    i_wr_en    = wr;
    i_wr_data  = d;
    i_cfg_bits = cfg;
    i_rd_ready = rdy;
    i_clr_ovf  = clr;
    pop = (exp_q.size() > 0) && rdy;
    n_chk++;
    if (o_rd_valid !== (exp_q.size() > 0)) begin
      n_fail++;
      $display("FAIL rd_valid: got %b want %b", o_rd_valid, exp_q.size() > 0);
    end
    if (pop) begin
      exp_d = exp_q.pop_front();
      n_chk++;
      if (o_rd_data !== exp_d) begin
        n_fail++;
        $display("FAIL rd_data: got %h want %h", o_rd_data, exp_d);
      end
    end
    acc = wr && ((exp_q.size() + (pop ? 1 : 0)) < DEP || pop);
    if (acc) begin
      msk = 8'((9'd1 << (5 + int'(cfg))) - 9'd1);
      exp_q.push_back(d & msk);
    end
    if (wr && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    @(posedge clk);
    #1;
    i_wr_en   = 1'b0;
    i_rd_ready = 1'b0;
    i_clr_ovf = 1'b0;
    n_chk++;
    if (o_level !== 5'(exp_q.size()) || o_empty !== (exp_q.size() == 0) ||
        o_full !== (exp_q.size() == DEP)) begin
      n_fail++;
      $display("FAIL status: level=%0d empty=%b full=%b want level=%0d",
               o_level, o_empty, o_full, exp_q.size());
    end
    n_chk++;
    if (o_overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %b want %b", o_overflow, m_ovf);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_chk++;
    if (o_rd_valid !== 1'b0 || o_level !== 5'd0 || o_empty !== 1'b1 || o_full !== 1'b0 ||
        o_overflow !== 1'b0 || o_timeout !== 1'b0 || o_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: valid=%b level=%0d empty=%b full=%b ovf=%b to=%b data=%h want 0/0/1/0/0/0/00",
               tag, o_rd_valid, o_level, o_empty, o_full, o_overflow, o_timeout, o_rd_data);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("reset_release");
    for (int i = 0; i < 50; i++) step(1'b0, 8'h00, 2'b11, 1'b0, 1'b0);
    n_chk++;
    if (o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: got %b want 0", o_timeout);
    end
  endtask

  task automatic test_masking;
    step(1'b1, 8'hFF, 2'b00, 1'b0, 1'b0);
    n_chk++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h1F) begin
      n_fail++;
      $display("FAIL mask_latency: valid=%b data=%h want 1 1f", o_rd_valid, o_rd_data);
    end
    step(1'b1, 8'hFF, 2'b10, 1'b0, 1'b0);
    step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0);
    n_chk++;
    if (o_rd_data !== 8'h7F) begin
      n_fail++;
      $display("FAIL mask_7bit: got %h want 7f", o_rd_data);
    end
    step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0);
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 2'b11, 1'b0, 1'b0);
      if (i == 15) begin
        n_chk++;
        if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_16: full=%b ovf=%b want 1 0", o_full, o_overflow);
        end
      end
    end
    n_chk++;
    if (o_overflow !== 1'b1 || o_level !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow_17: ovf=%b level=%0d want 1 16", o_overflow, o_level);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (o_rd_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_order: got %h want %h", o_rd_data, 8'(i));
      end
      step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0);
    end
    step(1'b0, 8'h00, 2'b11, 1'b0, 1'b1);
    n_chk++;
    if (o_overflow !== 1'b0 || o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_ovf: ovf=%b empty=%b want 0 1", o_overflow, o_empty);
    end
  endtask

  task automatic test_full_simul;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 2'b11, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 2'b11, 1'b1, 1'b0);
    n_chk++;
    if (o_level !== 5'd16 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_simul: level=%0d ovf=%b want 16 0", o_level, o_overflow);
    end
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0);
    n_chk++;
    if (o_rd_data !== 8'hA5 || o_level !== 5'd1) begin
      n_fail++;
      $display("FAIL full_simul_last: data=%h level=%0d want a5 1", o_rd_data, o_level);
    end
    step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    int max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 2'b11, 1'b1, 1'b0);
      if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        step(1'b0, 8'h00, 2'b11, 1'b0, 1'b0);
        if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
      end
    end
    step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0);
    n_chk++;
    if (max_lvl > 2 || o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: max_level=%0d empty=%b want <=2 1", max_lvl, o_empty);
    end
  endtask

  task automatic test_timeout_reset;
    step(1'b1, 8'h42, 2'b11, 1'b0, 1'b0);
    for (int j = 1; j < TO; j++) step(1'b0, 8'h00, 2'b11, 1'b0, 1'b0);
    n_chk++;
    if (o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got %b want 0 at %0d cycles", o_timeout, TO - 1);
    end
    step(1'b0, 8'h00, 2'b11, 1'b0, 1'b0);
    n_chk++;
    if (o_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_assert: got %b want 1 at %0d cycles", o_timeout, TO);
    end
    for (int j = 0; j < 5; j++) step(1'b0, 8'h00, 2'b11, 1'b0, 1'b0);
    n_chk++;
    if (o_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hold: got %b want 1", o_timeout);
    end
    step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0);
    n_chk++;
    if (o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b want 0", o_timeout);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 2'b11, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) step(1'b0, 8'h00, 2'b11, 1'b0, 1'b0);
    // Make the overflow flag set too, so the reset has something to clear.
    for (int i = 0; i < 14; i++) step(1'b1, 8'(i), 2'b11, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    exp_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("after_reset");
    step(1'b1, 8'hC3, 2'b11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_masking();
    test_fill_overflow();
    test_full_simul();
    test_wrap();
    test_timeout_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. Captures each completed character on the receiver's one-cycle done strobe, masks it to the configured character length, and holds it in a circular FIFO. Presents it to the host/bus side as a first-word-fall-through valid/ready stream, with level, overflow and character-timeout status.

## Interface
Parameters:
- DATA_WIDTH, 8, character width; matches the receiver's data width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 34720, idle cycles before timeout. This is 4 characters × 10 bits × 868 clocks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_wr_data  in  DATA_WIDTH  character from the receiver's data output.
- i_wr_en  in  1  one-cycle strobe from the receiver's done output.
- i_cfg_bits  in  2  character length: 00=5, 01=6, 10=7, 11=8 bits.
- o_rd_data  out  DATA_WIDTH  head-of-FIFO character.
- o_rd_valid  out  1  FIFO not empty.
- i_rd_ready  in  1  consumer accepts o_rd_data.
- i_clr_ovf  in  1  clears o_overflow.
- o_level  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- o_full  out  1  o_level == DEPTH.
- o_empty  out  1  o_level == 0.
- o_overflow  out  1  sticky; set when a character was dropped.
- o_timeout  out  1  data pending and no FIFO activity for TIMEOUT_CYC cycles.

## Operation
- Reset values: o_rd_valid=0, o_level=0, o_empty=1, o_full=0, o_overflow=0, o_timeout=0, o_rd_data=0. Pointers and timeout counter reset to 0.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits with an extra wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2·DEPTH.
- Write: on i_wr_en, the character is stored at wr_ptr and wr_ptr increments.
  - Stored value = i_wr_data with bits [DATA_WIDTH-1 : 5+i_cfg_bits] forced to 0.
- Pop: when o_rd_valid && i_rd_ready, rd_ptr increments.
- Full and i_wr_en with no pop: the character is dropped, pointers are unchanged, and o_overflow is set.
- Full and i_wr_en with a pop in the same cycle: the write is accepted and o_level stays at DEPTH. No overflow.
- Empty and i_wr_en with i_rd_ready: no pop occurs, because o_rd_valid is 0 that cycle. The write is accepted.
- Write and pop in the same cycle when not full: o_level is unchanged.
- Overflow flag:
  - i_clr_ovf clears it.
  - If a set and a clear occur in the same cycle, the set wins.
- Timeout counter (width $clog2(TIMEOUT_CYC+1)):
  - Cleared on any accepted write, any pop, or when empty.
  - Otherwise increments, saturating at TIMEOUT_CYC.
  - o_timeout = (counter == TIMEOUT_CYC) && !o_empty.
  - Dropped writes do not clear the counter.
- i_cfg_bits is sampled only on write. Changing it does not alter stored data.

## Timing
- Write to visibility: character written on edge N has o_rd_valid=1 and o_rd_data valid after edge N+1. Latency is 1 cycle.
- o_rd_data is the registered/array read of mem[rd_ptr]. It is stable while o_rd_valid && !i_rd_ready.
- Pop to next word: the next entry appears the cycle after the accepting edge.
- Status outputs: o_level, o_full, o_empty and o_overflow update on the edge that causes the change. They are registered or derived purely from registers; no combinational path from inputs.
- o_timeout asserts TIMEOUT_CYC cycles after the last activity. It deasserts the cycle after the next write or pop.
- Reset asserted mid-operation: all contents are discarded immediately (asynchronous). Stored words are not cleared and are not observable, since valid=0.
- Throughput: one write and one pop per cycle sustained.

## Structure
- Shared package uart_pkg:
  - cfg_bits encoding constants: BITS_5..BITS_8.
  - Baud limit constants: 867, 5207, 10415.
  - Default TIMEOUT_CYC.
- Natural sub-module: sync_fifo.
  - Generic pointer/memory/level logic, parameterised by DATA_WIDTH and DEPTH.
  - Has the same full/empty/simultaneous rules as above and no masking or timeout.
- uart_rx_fifo wraps sync_fifo and adds masking, overflow and timeout. Total 150–300 lines.

## Test plan
- Reset then idle: after rst release, o_empty=1, o_level=0, o_rd_valid=0. Hold 50 cycles and check o_timeout=0.
- Masking: with cfg_bits=00, write 0xFF; with cfg_bits=10, write 0xFF.
  - Pops return 0x1F then 0x7F.
  - o_rd_valid rises exactly 1 cycle after the first write.
- Fill and overflow: with DEPTH=16 and i_rd_ready=0, write 0x00..0x10 (17 strobes).
  - o_full=1 after the 16th write. o_overflow=1 after the 17th.
  - Draining yields 0x00..0x0F in order, without 0x10.
  - i_clr_ovf then clears o_overflow.
- Full with simultaneous write and pop: when full, strobe i_wr_en=0xA5 with i_rd_ready=1.
  - Level stays 16 and o_overflow stays 0.
  - 0xA5 is popped last, after 15 more pops.
- Wrap-around: 40 interleaved write/pop pairs of an incrementing pattern with a random ready stall.
  - Output order matches input order.
  - o_level never exceeds 2.
- Timeout and reset mid-op: write one byte, hold i_rd_ready=0.
  - o_timeout=1 exactly TIMEOUT_CYC cycles later; clears 1 cycle after the pop.
  - Repeat with 3 bytes and assert rst mid-wait: all outputs return to reset values asynchronously.
